// File: rtl/rv32i_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_fetch_unit
// Brief    : RV32I instruction-fetch front end. It keeps one outstanding L1I
//            request and holds returned words with their PCs in a small FIFO.
//            Defining FETCH_MISALIGN_EN adds fetch_fault for misaligned
//            redirect targets.
// Revision : 1.0
// ============================================================================
module rv32i_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enb,
    output logic            req_valid,
    output logic [PC_W-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_data,
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    output logic [PC_W-1:0] inst_pc,
    input  logic            inst_ready,
`ifdef FETCH_MISALIGN_EN
    output logic            fetch_fault,
`endif
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc
);

    localparam int                 c_PTR_W      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int                 c_CNT_W      = $clog2(FQ_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(FQ_DEPTH);
    localparam logic [PC_W-1:0]    c_ALIGN_MASK = ~(PC_W'(3));
    localparam logic [PC_W-1:0]    c_PC_STEP    = PC_W'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                req_valid_q;
    logic [PC_W-1:0]     fetch_pc_q;
    logic [PC_W-1:0]     req_pc_q;
    logic                fault_q;

    logic [c_PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [c_CNT_W-1:0]  count_q;
    logic [c_CNT_W-1:0]  w_count_d;
    logic [31:0]         data_q [FQ_DEPTH];
    logic [PC_W-1:0]     pc_q   [FQ_DEPTH];

    logic w_misalign, w_fault_d, w_go, w_hs, w_push, w_pop, w_room;

`ifdef FETCH_MISALIGN_EN
    assign w_misalign  = |redirect_pc[1:0];
    assign fetch_fault = fault_q;
`else
    assign w_misalign  = 1'b0;
`endif

    // A pending fault blocks every path that would start a new request.
    assign w_fault_d = redirect ? w_misalign : fault_q;
    assign w_go      = enb & ~w_fault_d;
    assign w_hs      = (state_q == S_ISSUE) & req_ready;
    assign w_push    = (state_q == S_WAIT) & rsp_valid & ~redirect;
    assign w_pop     = inst_valid & inst_ready & ~redirect;
    assign w_count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_room    = (count_q < c_DEPTH);

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            case (state_q)
                S_IDLE:  state_d = w_go ? S_ISSUE : S_IDLE;
                S_ISSUE: state_d = req_ready ? S_FLUSH : (w_fault_d ? S_IDLE : S_ISSUE);
                S_WAIT:  state_d = rsp_valid ? (w_go ? S_ISSUE : S_IDLE) : S_FLUSH;
                S_FLUSH: state_d = rsp_valid ? (w_go ? S_ISSUE : S_IDLE) : S_FLUSH;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE:  state_d = (w_go && w_room) ? S_ISSUE : S_IDLE;
                S_ISSUE: begin
                    if (req_ready)   state_d = S_WAIT;
                    else if (!enb)   state_d = S_IDLE;
                end
                S_WAIT: begin
                    if (rsp_valid)
                        state_d = (w_go && (w_count_d < c_DEPTH)) ? S_ISSUE : S_IDLE;
                end
                S_FLUSH: begin
                    if (rsp_valid)   state_d = w_go ? S_ISSUE : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= (state_d == S_ISSUE);
            fault_q     <= w_fault_d;
            if (redirect)
                fetch_pc_q <= redirect_pc & c_ALIGN_MASK;
            else if (w_hs)
                fetch_pc_q <= fetch_pc_q + c_PC_STEP;
            if (w_hs)
                req_pc_q <= fetch_pc_q;
        end
    end

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(FQ_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                data_q[wr_ptr_q] <= rsp_data;
                pc_q[wr_ptr_q]   <= req_pc_q;
                wr_ptr_q         <= f_ptr_inc(wr_ptr_q);
            end
            if (w_pop)
                rd_ptr_q <= f_ptr_inc(rd_ptr_q);
            count_q <= w_count_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = data_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch_unit.sv
`default_nettype none
// Testbench for rv32i_fetch_unit: directed scenarios plus random traffic,
// checked each cycle against a transaction-level fetch/queue model.
module tb_rv32i_fetch_unit;

    localparam int              PC_W       = 32;
    localparam logic [PC_W-1:0] RESET_PC   = 32'h0;
    localparam int              FQ_DEPTH   = 2;
    localparam logic [PC_W-1:0] ALIGN_MASK = ~32'h3;

    logic            clk;
    logic            rst;
    logic            enb;
    logic            req_valid;
    logic [PC_W-1:0] req_addr;
    logic            req_ready;
    logic            rsp_valid;
    logic [31:0]     rsp_data;
    logic            inst_valid;
    logic [31:0]     inst_data;
    logic [PC_W-1:0] inst_pc;
    logic            inst_ready;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
`ifdef FETCH_MISALIGN_EN
    logic            fetch_fault;
`endif

    rv32i_fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
`ifdef FETCH_MISALIGN_EN
        .fetch_fault (fetch_fault),
`endif
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     data;
    } ent_t;

    // Model: expected fetch address, the one outstanding cache access and
    // the decode-visible queue contents.
    ent_t            m_q[$];
    bit              m_pres, m_out, m_stale, m_fault;
    logic [PC_W-1:0] m_addr, m_out_pc;
    logic [31:0]     m_out_data;
    int              m_lat;
    int              lat_lo, lat_hi;

    int              n_chk, n_fail, cyc, n_pop_obs;
    logic [PC_W-1:0] hs_addr[$];
    int              hs_cyc[$];
    int              first_valid, valid_seen;
    logic [PC_W-1:0] first_pc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        enb         = 1'($urandom);
        req_ready   = 1'($urandom);
        inst_ready  = 1'($urandom);
        rsp_valid   = 1'($urandom);
        rsp_data    = $urandom;
        redirect    = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, RESET_PC);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
`ifdef FETCH_MISALIGN_EN
        chk("rst_fetch_fault", fetch_fault, 0);
`endif
        m_q.delete();
        m_pres = 0; m_out = 0; m_stale = 0; m_fault = 0;
        m_addr = RESET_PC;
        cyc = 0; first_valid = -1; valid_seen = 0;
        hs_addr.delete(); hs_cyc.delete();
    endtask

    task automatic step(input bit e, input bit rr, input bit ir, input bit rd,
                        input logic [PC_W-1:0] rpc, input bit junk);
        bit   rsp, hs, fault_n, nxt;
        int   pre_size;
        ent_t ent;
        @(negedge clk);
        chk("req_valid", req_valid, m_pres);
        if (m_pres) chk("req_addr", req_addr, m_addr);
        chk("inst_valid", inst_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("inst_pc", inst_pc, m_q[0].pc);
            chk("inst_data", inst_data, m_q[0].data);
        end
`ifdef FETCH_MISALIGN_EN
        chk("fetch_fault", fetch_fault, m_fault);
`endif
        if (inst_valid && first_valid < 0) begin
            first_valid = cyc;
            first_pc    = inst_pc;
        end
        if (inst_valid) valid_seen++;
        if (inst_valid && ir && !rd) n_pop_obs++;
        if (req_valid && rr) begin
            hs_addr.push_back(req_addr);
            hs_cyc.push_back(cyc);
        end

        rsp         = m_out && (m_lat == 0);
        rst         = 1'b0;
        enb         = e;
        req_ready   = rr;
        inst_ready  = ir;
        redirect    = rd;
        redirect_pc = rpc;
        rsp_valid   = rsp || (junk && !m_out);
        rsp_data    = rsp ? m_out_data : $urandom;

        hs       = m_pres && rr;
        pre_size = m_q.size();
        fault_n  = m_fault;
        if (rd) begin
`ifdef FETCH_MISALIGN_EN
            fault_n = |rpc[1:0];
`else
            fault_n = 1'b0;
`endif
        end
        if (rd) begin
            m_q.delete();
        end else begin
            if (pre_size != 0 && ir) void'(m_q.pop_front());
            if (rsp && !m_stale) begin
                ent.pc   = m_out_pc;
                ent.data = m_out_data;
                m_q.push_back(ent);
            end
        end

        // A new request may be presented only with nothing in flight, fetch
        // enabled, no fault, and queue room (redirect/stale paths free it).
        if (hs || (m_out && !rsp))  nxt = 0;
        else if (m_pres)            nxt = rd ? !fault_n : e;
        else if (rsp)               nxt = e && !fault_n && (rd || m_stale || m_q.size() < FQ_DEPTH);
        else                        nxt = e && !fault_n && (rd || pre_size < FQ_DEPTH);

        if (rsp) begin
            m_out = 0;
        end else if (m_out) begin
            if (m_lat > 0) m_lat--;
            if (rd) m_stale = 1;
        end
        if (hs) begin
            m_out      = 1;
            m_out_pc   = m_addr;
            m_out_data = $urandom;
            m_stale    = rd;
            m_lat      = $urandom_range(lat_hi, lat_lo);
            m_addr     = m_addr + 32'd4;
        end
        if (rd) m_addr = rpc & ALIGN_MASK;
        m_fault = fault_n;
        m_pres  = nxt;
        cyc++;
    endtask

    initial begin
        bit              e, rr, ir, rd, jk;
        logic [PC_W-1:0] rpc;
        n_chk = 0; n_fail = 0; n_pop_obs = 0; cyc = 0;
        lat_lo = 0; lat_hi = 0;

        // Streaming with a 1-cycle cache: one fetch every 2 cycles.
        do_reset();
        repeat (8) step(1, 1, 1, 0, '0, 0);
        chk("A_hs_count", hs_addr.size(), 4);
        if (hs_addr.size() >= 3) begin
            chk("A_hs0_addr", hs_addr[0], 32'h0);
            chk("A_hs1_addr", hs_addr[1], 32'h4);
            chk("A_hs2_addr", hs_addr[2], 32'h8);
            chk("A_hs0_cyc", hs_cyc[0], 1);
            chk("A_hs1_cyc", hs_cyc[1], 3);
        end
        chk("A_first_valid_cyc", first_valid, 3);
        chk("A_first_pc", first_pc, 32'h0);

        // Full queue stops issue; a single pop lets exactly one more fetch go.
        do_reset();
        repeat (10) step(1, 1, 0, 0, '0, 0);
        chk("B_hs_count_full", hs_addr.size(), 2);
        chk("B_req_blocked", req_valid, 0);
        step(1, 1, 1, 0, '0, 0);
        repeat (6) step(1, 1, 0, 0, '0, 0);
        chk("B_hs_count_after_pop", hs_addr.size(), 3);
        if (hs_addr.size() >= 3) chk("B_hs2_addr", hs_addr[2], 32'h8);

        // Redirect while waiting; the stale response arrives two cycles later.
        do_reset();
        lat_lo = 2; lat_hi = 2;
        step(1, 1, 1, 0, '0, 0);
        step(1, 1, 1, 0, '0, 0);
        step(1, 1, 1, 1, 32'h100, 0);
        repeat (4) step(1, 1, 1, 0, '0, 0);
        chk("D_hs_count", hs_addr.size(), 2);
        if (hs_addr.size() >= 2) chk("D_hs1_addr", hs_addr[1], 32'h100);
        chk("D_no_stale_valid", valid_seen, 0);

`ifdef FETCH_MISALIGN_EN
        do_reset();
        lat_lo = 0; lat_hi = 0;
        step(0, 1, 1, 1, 32'h102, 0);
        repeat (3) step(1, 1, 1, 0, '0, 0);
        chk("F_fault_set", fetch_fault, 1);
        chk("F_no_issue", hs_addr.size(), 0);
        step(1, 1, 1, 1, 32'h200, 0);
        repeat (2) step(1, 1, 1, 0, '0, 0);
        chk("F_fault_clear", fetch_fault, 0);
        if (hs_addr.size() >= 1) chk("F_hs0_addr", hs_addr[0], 32'h200);
        else chk("F_hs_count", hs_addr.size(), 1);
`endif

        // Random traffic with variable cache latency and redirects.
        do_reset();
        lat_lo = 0; lat_hi = 3;
        n_pop_obs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            e   = ($urandom_range(0, 99) < 85);
            rr  = ($urandom_range(0, 99) < 70);
            ir  = ($urandom_range(0, 99) < 60);
            rd  = ($urandom_range(0, 99) < 5);
            jk  = ($urandom_range(0, 99) < 20);
            rpc = PC_W'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 7) == 0) rpc = rpc | PC_W'($urandom_range(1, 3));
            step(e, rr, ir, rd, rpc, jk);
        end
        chk("R_liveness", n_pop_obs > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
